// File: rtl/booth_pkg.sv
// Shared constants and types for the Booth radix-2 multiply sequencer.
package booth_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned PROD_W = 32;
   localparam int unsigned STEP_W = 5;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/booth_if.sv
// Request/operation bus between a Booth sequencer and its client/accumulator.
interface booth_if;
   import booth_pkg::*;

   logic              start;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic              busy;
   logic              done;
   logic              startbit;
   logic [1:0]        addorsub;
   logic [PROD_W-1:0] b;
   logic [STEP_W-1:0] step;

   modport master (
      output start, mcand, mplier,
      input  busy, done, startbit, addorsub, b, step
   );

   modport slave (
      input  start, mcand, mplier,
      output busy, done, startbit, addorsub, b, step
   );

endinterface

// File: rtl/booth_recode.sv
// Radix-2 Booth recoder: maps the multiplier bit pair {q[i], q[i-1]} to an op code.
module booth_recode
   import booth_pkg::*;
(
   input  logic [1:0] pair,
   output logic [1:0] op
);

   always_comb begin
      op = OP_HOLD;
      case (pair)
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_HOLD;
      endcase
   end

endmodule

// File: rtl/booth_sequencer.sv
// Booth radix-2 sequencer issuing one add/sub/hold per step to an external accumulator.
// Optional feature: define BOOTH_EARLY_TERM_EN to stop once the remaining pairs are all holds.
module booth_sequencer
   import booth_pkg::*;
(
   input logic    clk,
   input logic    rst_n,
   booth_if.slave bus
);

   localparam logic [STEP_W-1:0] LastStep = STEP_W'(DATA_W - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mcand_q;
   logic [DATA_W:0]   q_q;
   logic [DATA_W:0]   q_shift;
   logic [STEP_W-1:0] i_q;
   logic [1:0]        rec_op;
   logic [PROD_W-1:0] mcand_ext;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              startbit_q, startbit_d;
   logic [1:0]        addorsub_q, addorsub_d;
   logic [PROD_W-1:0] b_q, b_d;
   logic [STEP_W-1:0] step_q, step_d;

   assign q_shift   = {q_q[DATA_W], q_q[DATA_W:1]};
   assign mcand_ext = {{(PROD_W - DATA_W){mcand_q[DATA_W-1]}}, mcand_q};

   booth_recode u_recode (
      .pair (q_q[1:0]),
      .op   (rec_op)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (bus.start) state_d = StRun;
         end
         StRun: begin
            if (i_q == LastStep) begin
               state_d = StDone;
`ifdef BOOTH_EARLY_TERM_EN
            // All-zeros or all-ones leaves only hold pairs, so nothing else changes the sum.
            end else if (q_shift == '0 || q_shift == '1) begin
               state_d = StDone;
`endif
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered, so they show the state of the previous cycle.
   always_comb begin
      busy_d     = 1'b0;
      done_d     = 1'b0;
      startbit_d = 1'b0;
      addorsub_d = OP_HOLD;
      b_d        = '0;
      step_d     = '0;
      case (state_q)
         StRun: begin
            busy_d     = 1'b1;
            startbit_d = 1'b1;
            step_d     = i_q;
            addorsub_d = rec_op;
            b_d        = mcand_ext << i_q;
            // First step with pair 00 adds zero so the accumulator starts from a clean value.
            if (i_q == '0 && q_q[1:0] == 2'b00) begin
               addorsub_d = OP_ADD;
               b_d        = '0;
            end
         end
         StDone: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q    <= '0;
         q_q        <= '0;
         i_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         startbit_q <= 1'b0;
         addorsub_q <= OP_HOLD;
         b_q        <= '0;
         step_q     <= '0;
      end else begin
         if (state_q == StIdle && bus.start) begin
            mcand_q <= bus.mcand;
            q_q     <= {bus.mplier, 1'b0};
            i_q     <= '0;
         end else if (state_q == StRun) begin
            q_q <= q_shift;
            i_q <= i_q + STEP_W'(1);
         end
         busy_q     <= busy_d;
         done_q     <= done_d;
         startbit_q <= startbit_d;
         addorsub_q <= addorsub_d;
         b_q        <= b_d;
         step_q     <= step_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.startbit = startbit_q;
   assign bus.addorsub = addorsub_q;
   assign bus.b        = b_q;
   assign bus.step     = step_q;

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed testbench for booth_sequencer: replays issued ops into a local accumulator.
module tb_booth_sequencer;
   import booth_pkg::*;

`ifdef BOOTH_EARLY_TERM_EN
   localparam int EtLimit  = 15;
   localparam int DoneZero = 2;
   localparam int DoneNeg  = 4;
   localparam int DoneBase = 5;
`else
   localparam int EtLimit  = 0;
   localparam int DoneZero = 17;
   localparam int DoneNeg  = 17;
   localparam int DoneBase = 17;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   booth_if bus ();

   booth_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          bad_ops = 0;
   logic [1:0]  op_log [16];
   logic [31:0] b_log  [16];

   // Done edge: first step i whose remaining multiplier bits [15:i] are all equal, plus 2.
   function automatic int exp_done(input logic [15:0] mp);
      for (int i = 0; i < EtLimit; i++) begin
         int t;
         t = int'($signed(mp)) >>> i;
         if (t == 0 || t == -1) return i + 2;
      end
      return 17;
   endfunction

   task automatic collect(input int pulse_at, output logic [31:0] sum, output int done_edge,
                          output int nsteps);
      sum = '0;
      done_edge = -1;
      nsteps = 0;
      for (int s = 0; s < 16; s++) begin
         op_log[s] = 2'b11;
         b_log[s]  = '0;
      end
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (pulse_at >= 0) bus.start = 1'b0;
         if (bus.startbit) begin
            if (bus.addorsub == 2'b11 || bus.step != 5'(nsteps)) bad_ops++;
            if (bus.step < 5'd16) begin
               op_log[bus.step[3:0]] = bus.addorsub;
               b_log[bus.step[3:0]]  = bus.b;
            end
            if (bus.addorsub == OP_ADD) sum = sum + bus.b;
            if (bus.addorsub == OP_SUB) sum = sum - bus.b;
            nsteps++;
            if (int'(bus.step) == pulse_at) begin
               bus.start  = 1'b1;
               bus.mcand  = 16'h7777;
               bus.mplier = 16'h0F0F;
            end
         end
         if (bus.done) begin
            done_edge = e;
            break;
         end
      end
   endtask

   task automatic do_op(input logic [15:0] mc, input logic [15:0] mp, input int pulse_at,
                        output logic [31:0] sum, output int done_edge, output int nsteps);
      @(negedge clk);
      bus.mcand  = mc;
      bus.mplier = mp;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      collect(pulse_at, sum, done_edge, nsteps);
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if ({bus.busy, bus.done, bus.startbit, bus.addorsub, bus.b, bus.step} !== 42'd0) begin
         n_err++;
         $display("FAIL reset_hold: outputs=%h want 0",
                  {bus.busy, bus.done, bus.startbit, bus.addorsub, bus.b, bus.step});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.busy, bus.done, bus.startbit, bus.addorsub, bus.b, bus.step} !== 42'd0) begin
         n_err++;
         $display("FAIL reset_idle: outputs=%h want 0",
                  {bus.busy, bus.done, bus.startbit, bus.addorsub, bus.b, bus.step});
      end
   endtask

   task automatic test_basic();
      logic [1:0]  eop [4] = '{OP_SUB, OP_ADD, OP_SUB, OP_ADD};
      logic [31:0] eb  [4] = '{32'd3, 32'd6, 32'd12, 32'd24};
      logic [31:0] sum;
      int          de, ns;
      do_op(16'd3, 16'd5, -1, sum, de, ns);
      for (int s = 0; s < 4; s++) begin
         n_vec++;
         if (op_log[s] !== eop[s] || b_log[s] !== eb[s]) begin
            n_err++;
            $display("FAIL basic_step%0d: got op=%b b=%h want op=%b b=%h",
                     s, op_log[s], b_log[s], eop[s], eb[s]);
         end
      end
      for (int s = 4; s < ns && s < 16; s++) begin
         n_vec++;
         if (op_log[s] !== OP_HOLD) begin
            n_err++;
            $display("FAIL basic_hold%0d: got op=%b want %b", s, op_log[s], OP_HOLD);
         end
      end
      n_vec++;
      if (sum !== 32'd15) begin
         n_err++;
         $display("FAIL basic_sum: got %h want %h", sum, 32'd15);
      end
      n_vec++;
      if (de != DoneBase || ns != DoneBase - 1) begin
         n_err++;
         $display("FAIL basic_latency: got done_edge=%0d steps=%0d want %0d/%0d",
                  de, ns, DoneBase, DoneBase - 1);
      end
   endtask

   task automatic test_zero_mplier();
      logic [31:0] sum;
      int          de, ns;
      do_op(16'h1234, 16'h0000, -1, sum, de, ns);
      n_vec++;
      if (op_log[0] !== OP_ADD || b_log[0] !== 32'd0) begin
         n_err++;
         $display("FAIL zero_step0: got op=%b b=%h want op=01 b=0", op_log[0], b_log[0]);
      end
      n_vec++;
      if (sum !== 32'd0) begin
         n_err++;
         $display("FAIL zero_sum: got %h want 0", sum);
      end
      n_vec++;
      if (de != DoneZero) begin
         n_err++;
         $display("FAIL zero_latency: got %0d want %0d", de, DoneZero);
      end
   endtask

   task automatic test_min_mplier();
      logic [31:0] sum;
      int          de, ns, subs;
      do_op(16'h0001, 16'h8000, -1, sum, de, ns);
      subs = 0;
      for (int s = 0; s < 16; s++) if (op_log[s] == OP_SUB) subs++;
      n_vec++;
      if (op_log[0] !== OP_ADD || b_log[0] !== 32'd0) begin
         n_err++;
         $display("FAIL min_step0: got op=%b b=%h want op=01 b=0", op_log[0], b_log[0]);
      end
      n_vec++;
      if (op_log[15] !== OP_SUB || b_log[15] !== 32'h0000_8000 || subs != 1) begin
         n_err++;
         $display("FAIL min_step15: got op=%b b=%h subs=%0d want op=10 b=00008000 subs=1",
                  op_log[15], b_log[15], subs);
      end
      n_vec++;
      if (sum !== 32'hFFFF_8000 || de != 17) begin
         n_err++;
         $display("FAIL min_sum: got %h edge %0d want ffff8000 edge 17", sum, de);
      end
   endtask

   task automatic test_negative();
      logic [31:0] sum;
      int          de, ns;
      do_op(16'hFFFE, 16'hFFFD, -1, sum, de, ns);
      n_vec++;
      if (sum !== 32'd6) begin
         n_err++;
         $display("FAIL neg_sum: got %h want 6", sum);
      end
      n_vec++;
      if (de != DoneNeg) begin
         n_err++;
         $display("FAIL neg_latency: got %0d want %0d", de, DoneNeg);
      end
   endtask

   task automatic test_products();
      logic [15:0] mcs [6] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h00A5};
      logic [15:0] mps [6] = '{16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'hFF5A};
      logic [31:0] sum, want;
      int          de, ns;
      for (int k = 0; k < 6; k++) begin
         do_op(mcs[k], mps[k], -1, sum, de, ns);
         want = 32'(int'($signed(mcs[k])) * int'($signed(mps[k])));
         if (k == 0) want = 32'h4000_0000;
         n_vec++;
         if (sum !== want || de != exp_done(mps[k])) begin
            n_err++;
            $display("FAIL product_%0d: got %h edge %0d want %h edge %0d",
                     k, sum, de, want, exp_done(mps[k]));
         end
      end
      n_vec++;
      if (bad_ops != 0) begin
         n_err++;
         $display("FAIL op_sequence: got %0d illegal/out-of-order steps want 0", bad_ops);
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] sum;
      int          de, ns;
      do_op(16'h0007, 16'h1234, 5, sum, de, ns);
      n_vec++;
      if (sum !== 32'h0000_7F6C || de != exp_done(16'h1234)) begin
         n_err++;
         $display("FAIL ignore_start: got %h edge %0d want 00007f6c edge %0d",
                  sum, de, exp_done(16'h1234));
      end
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (bus.startbit !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL ignore_no_rerun: got startbit=%b busy=%b want 0/0",
                  bus.startbit, bus.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] sum;
      int          de, ns;
      bit          seen;
      seen = 1'b0;
      @(negedge clk);
      bus.mcand  = 16'h0101;
      bus.mplier = 16'h7F01;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int e = 0; e < 20 && !seen; e++) begin
         @(posedge clk);
         #1;
         if (bus.startbit && bus.step == 5'd7) seen = 1'b1;
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (!seen || {bus.busy, bus.done, bus.startbit, bus.addorsub, bus.b, bus.step} !== 42'd0)
      begin
         n_err++;
         $display("FAIL rst_mid_run: got seen=%0b outputs=%h want seen=1 outputs=0", seen,
                  {bus.busy, bus.done, bus.startbit, bus.addorsub, bus.b, bus.step});
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(16'hFF9C, 16'h0123, -1, sum, de, ns);
      n_vec++;
      if (sum !== 32'(-29100) || de != exp_done(16'h0123)) begin
         n_err++;
         $display("FAIL rst_restart: got %h edge %0d want %h edge %0d",
                  sum, de, 32'(-29100), exp_done(16'h0123));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] sum;
      int          de, ns;
      @(negedge clk);
      bus.mcand  = 16'h0011;
      bus.mplier = 16'h0022;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      collect(-1, sum, de, ns);
      bus.mcand  = 16'hFFF0;
      bus.mplier = 16'h0013;
      n_vec++;
      if (sum !== 32'd578 || de != exp_done(16'h0022)) begin
         n_err++;
         $display("FAIL b2b_first: got %h edge %0d want 00000242 edge %0d",
                  sum, de, exp_done(16'h0022));
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n_vec++;
      if (bus.startbit !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_gap: got startbit=%b busy=%b want 0/0", bus.startbit, bus.busy);
      end
      collect(-1, sum, de, ns);
      n_vec++;
      if (sum !== 32'(-304) || de != exp_done(16'h0013)) begin
         n_err++;
         $display("FAIL b2b_second: got %h edge %0d want %h edge %0d",
                  sum, de, 32'(-304), exp_done(16'h0013));
      end
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.mcand  = '0;
      bus.mplier = '0;
      test_reset();
      test_basic();
      test_zero_mplier();
      test_min_mplier();
      test_negative();
      test_products();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
